// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
// -----------------------------------------------------------------------------
// Purpose:
//   Execute-stage ALU of the MIPS datapath. It takes one operation per
//   i_valid/o_ready handshake. Logic, arithmetic, compare and lui complete with
//   1-cycle latency. Shifts use a 1-bit iterative shifter, so a shift by n takes
//   n+1 cycles. A shift by 0 completes in 1 cycle like any other operation.
//
// Parameters:
//   NB_DATA        operand/result width
//   NB_ALU_CONTROL ALU operation code width
//   NB_SHAMT       shift-amount width
//
// Ports:
//   i_clock      clock; all state changes on the rising edge
//   i_reset      synchronous, active-high reset
//   i_valid      operation request; accepted when i_valid && o_ready
//   i_alu_code   operation code
//   i_dato_a     operand A (rs)
//   i_dato_b     operand B (rt or extended immediate)
//   i_shamt      shift amount taken from the instruction
//   i_shift_var  1: shift amount = i_dato_a[NB_SHAMT-1:0], 0: i_shamt
//   o_ready      unit can accept an operation (low while a shift is running)
//   o_valid      one-cycle pulse; o_result/o_zero hold a new result
//   o_result     last completed result
//   o_zero       o_result == 0
// -----------------------------------------------------------------------------
module alu_exec_unit #(
   parameter int unsigned NB_DATA        = 32,
   parameter int unsigned NB_ALU_CONTROL = 4,
   parameter int unsigned NB_SHAMT       = 5
) (
   input  logic                      i_clock,
   input  logic                      i_reset,
   input  logic                      i_valid,
   input  logic [NB_ALU_CONTROL-1:0] i_alu_code,
   input  logic [NB_DATA-1:0]        i_dato_a,
   input  logic [NB_DATA-1:0]        i_dato_b,
   input  logic [NB_SHAMT-1:0]       i_shamt,
   input  logic                      i_shift_var,
   output logic                      o_ready,
   output logic                      o_valid,
   output logic [NB_DATA-1:0]        o_result,
   output logic                      o_zero
);

   // ---------------------------------------------------------------------------
   // Operation codes
   // ---------------------------------------------------------------------------
   localparam logic [NB_ALU_CONTROL-1:0] OP_SLL  = 4'b0000;
   localparam logic [NB_ALU_CONTROL-1:0] OP_SRL  = 4'b0001;
   localparam logic [NB_ALU_CONTROL-1:0] OP_SRA  = 4'b0010;
   localparam logic [NB_ALU_CONTROL-1:0] OP_LUI  = 4'b0011;
   localparam logic [NB_ALU_CONTROL-1:0] OP_ADDU = 4'b0110;
   localparam logic [NB_ALU_CONTROL-1:0] OP_SUBU = 4'b0111;
   localparam logic [NB_ALU_CONTROL-1:0] OP_AND  = 4'b1000;
   localparam logic [NB_ALU_CONTROL-1:0] OP_OR   = 4'b1001;
   localparam logic [NB_ALU_CONTROL-1:0] OP_XOR  = 4'b1010;
   localparam logic [NB_ALU_CONTROL-1:0] OP_NOR  = 4'b1011;
   localparam logic [NB_ALU_CONTROL-1:0] OP_SLT  = 4'b1100;

   // Shift kind kept while iterating (low two bits of the shift opcodes)
   localparam logic [1:0] SH_LEFT  = 2'b00;
   localparam logic [1:0] SH_RIGHT = 2'b01;

   // ---------------------------------------------------------------------------
   // FSM states
   // ---------------------------------------------------------------------------
   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_SHIFT = 1'b1;

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   logic                r_state;
   logic [NB_DATA-1:0]  r_work;
   logic [NB_SHAMT-1:0] r_count;
   logic [1:0]          r_shift_op;
   logic [NB_DATA-1:0]  r_result;
   logic                r_zero;
   logic                r_valid;

   // ---------------------------------------------------------------------------
   // Wires
   // ---------------------------------------------------------------------------
   logic                w_accept;
   logic                w_is_shift;
   logic [NB_SHAMT-1:0] w_shift_amt;
   logic                w_start_shift;
   logic [NB_DATA-1:0]  w_alu_result;
   logic [NB_DATA-1:0]  w_work_step;
   logic                w_last_step;

   logic                w_state_next;
   logic [NB_DATA-1:0]  w_work_next;
   logic [NB_SHAMT-1:0] w_count_next;
   logic [1:0]          w_shift_op_next;
   logic [NB_DATA-1:0]  w_result_next;
   logic                w_zero_next;
   logic                w_valid_next;

   // ---------------------------------------------------------------------------
   // Handshake and operation decode
   // ---------------------------------------------------------------------------
   assign o_ready  = (r_state == ST_IDLE);
   assign w_accept = i_valid && o_ready;

   assign w_is_shift = (i_alu_code == OP_SLL) || (i_alu_code == OP_SRL) ||
                       (i_alu_code == OP_SRA);

   assign w_shift_amt = i_shift_var ? i_dato_a[NB_SHAMT-1:0] : i_shamt;

   // Shift by zero bypasses the iterative shifter and finishes like a 1-cycle op
   assign w_start_shift = w_accept && w_is_shift && (w_shift_amt != '0);

   // ---------------------------------------------------------------------------
   // Single-cycle datapath
   // ---------------------------------------------------------------------------
   always_comb begin
      w_alu_result = '0;
      case (i_alu_code)
         OP_SLL,
         OP_SRL,
         OP_SRA:  w_alu_result = i_dato_b;  // only reached with amount 0
         OP_LUI:  w_alu_result = i_dato_b << 16;
         OP_ADDU: w_alu_result = i_dato_a + i_dato_b;
         OP_SUBU: w_alu_result = i_dato_a - i_dato_b;
         OP_AND:  w_alu_result = i_dato_a & i_dato_b;
         OP_OR:   w_alu_result = i_dato_a | i_dato_b;
         OP_XOR:  w_alu_result = i_dato_a ^ i_dato_b;
         OP_NOR:  w_alu_result = ~(i_dato_a | i_dato_b);
         OP_SLT:  w_alu_result = {{(NB_DATA-1){1'b0}},
                                  ($signed(i_dato_a) < $signed(i_dato_b))};
         default: w_alu_result = '0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // One-bit shift step
   // ---------------------------------------------------------------------------
   always_comb begin
      w_work_step = r_work;
      case (r_shift_op)
         SH_LEFT:  w_work_step = {r_work[NB_DATA-2:0], 1'b0};
         SH_RIGHT: w_work_step = {1'b0, r_work[NB_DATA-1:1]};
         default:  w_work_step = {r_work[NB_DATA-1], r_work[NB_DATA-1:1]};
      endcase
   end

   assign w_last_step = (r_count == {{(NB_SHAMT-1){1'b0}}, 1'b1});

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_next    = r_state;
      w_work_next     = r_work;
      w_count_next    = r_count;
      w_shift_op_next = r_shift_op;
      w_result_next   = r_result;
      w_zero_next     = r_zero;
      w_valid_next    = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_start_shift) begin
               w_state_next    = ST_SHIFT;
               w_work_next     = i_dato_b;
               w_count_next    = w_shift_amt;
               w_shift_op_next = i_alu_code[1:0];
            end else if (w_accept) begin
               w_result_next = w_alu_result;
               w_zero_next   = (w_alu_result == '0);
               w_valid_next  = 1'b1;
            end
         end

         ST_SHIFT: begin
            w_work_next  = w_work_step;
            w_count_next = r_count - 1'b1;
            if (w_last_step) begin
               w_state_next  = ST_IDLE;
               w_result_next = w_work_step;
               w_zero_next   = (w_work_step == '0);
               w_valid_next  = 1'b1;
            end
         end

         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_work     <= '0;
         r_count    <= '0;
         r_shift_op <= SH_LEFT;
         r_result   <= '0;
         r_zero     <= 1'b1;
         r_valid    <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_work     <= w_work_next;
         r_count    <= w_count_next;
         r_shift_op <= w_shift_op_next;
         r_result   <= w_result_next;
         r_zero     <= w_zero_next;
         r_valid    <= w_valid_next;
      end
   end

   assign o_valid  = r_valid;
   assign o_result = r_result;
   assign o_zero   = r_zero;

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
// -----------------------------------------------------------------------------
// Self-checking bench for alu_exec_unit: a fixed vector table run back-to-back,
// hand-written multi-cycle shift/reset sequences, and random operations checked
// against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;

   logic        i_clock = 1'b0;
   logic        i_reset;
   logic        i_valid;
   logic [3:0]  i_alu_code;
   logic [31:0] i_dato_a;
   logic [31:0] i_dato_b;
   logic [4:0]  i_shamt;
   logic        i_shift_var;
   logic        o_ready;
   logic        o_valid;
   logic [31:0] o_result;
   logic        o_zero;

   int npass  = 0;
   int ntotal = 0;

   alu_exec_unit #(
      .NB_DATA        (32),
      .NB_ALU_CONTROL (4),
      .NB_SHAMT       (5)
   ) dut (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_valid     (i_valid),
      .i_alu_code  (i_alu_code),
      .i_dato_a    (i_dato_a),
      .i_dato_b    (i_dato_b),
      .i_shamt     (i_shamt),
      .i_shift_var (i_shift_var),
      .o_ready     (o_ready),
      .o_valid     (o_valid),
      .o_result    (o_result),
      .o_zero      (o_zero)
   );

   always #5 i_clock = ~i_clock;

   typedef struct {
      logic [3:0]  code;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  shamt;
      logic        var_sh;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntotal++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference model: result straight from the operation definitions
   function automatic logic [31:0] ref_result(input logic [3:0] code, input logic [31:0] a,
                                              input logic [31:0] b, input int n);
      longint sa;
      longint sb;
      logic signed [31:0] bs;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      bs = b;
      case (code)
         4'd0:    return b << n;
         4'd1:    return b >> n;
         4'd2:    return bs >>> n;
         4'd3:    return {b[15:0], 16'h0000};
         4'd6:    return a + b;
         4'd7:    return a - b;
         4'd8:    return a & b;
         4'd9:    return a | b;
         4'd10:   return a ^ b;
         4'd11:   return ~(a | b);
         4'd12:   return (sa < sb) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // Issue one operation from idle and check latency, ready-low window, result
   task automatic run_op(input string name, input logic [3:0] code, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] shamt, input logic var_sh,
                         input logic [31:0] exp);
      int n;
      int exp_lat;
      int k;
      logic ready_low_ok;
      n = var_sh ? int'(a[4:0]) : int'(shamt);
      exp_lat = (code <= 4'd2 && n != 0) ? n + 1 : 1;
      @(negedge i_clock);
      i_valid     = 1'b1;
      i_alu_code  = code;
      i_dato_a    = a;
      i_dato_b    = b;
      i_shamt     = shamt;
      i_shift_var = var_sh;
      @(posedge i_clock);
      @(negedge i_clock);
      // Operands after the accept edge must be ignored
      i_valid  = 1'b0;
      i_dato_a = $urandom;
      i_dato_b = $urandom;
      i_shamt  = 5'($urandom);
      k = 1;
      ready_low_ok = 1'b1;
      while (!o_valid && k < 40) begin
         if (o_ready) ready_low_ok = 1'b0;
         @(negedge i_clock);
         k++;
      end
      check({name, "_valid"}, 32'(o_valid), 32'd1);
      check({name, "_latency"}, 32'(k), 32'(exp_lat));
      check({name, "_ready_low"}, 32'(ready_low_ok), 32'd1);
      check({name, "_result"}, o_result, exp);
      check({name, "_zero"}, 32'(o_zero), 32'(exp == 32'd0));
      check({name, "_ready_done"}, 32'(o_ready), 32'd1);
      @(negedge i_clock);
      check({name, "_pulse"}, 32'(o_valid), 32'd0);
      check({name, "_hold"}, o_result, exp);
   endtask

   initial begin
      logic [31:0] ha;
      logic [31:0] hb;
      logic        seen;

      vecs[0]  = '{4'b0110, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 1'b0, 32'h0000_0000};
      vecs[1]  = '{4'b0111, 32'h0000_0005, 32'h0000_0007, 5'd0, 1'b0, 32'hFFFF_FFFE};
      vecs[2]  = '{4'b1100, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 1'b0, 32'h0000_0001};
      vecs[3]  = '{4'b1011, 32'h0000_0000, 32'h0000_0000, 5'd0, 1'b0, 32'hFFFF_FFFF};
      vecs[4]  = '{4'b0001, 32'h0000_0000, 32'h0000_1234, 5'd0, 1'b0, 32'h0000_1234};
      vecs[5]  = '{4'b0011, 32'h0000_0000, 32'h0000_ABCD, 5'd0, 1'b0, 32'hABCD_0000};
      vecs[6]  = '{4'b0101, 32'h0000_0005, 32'h0000_0006, 5'd0, 1'b0, 32'h0000_0000};
      vecs[7]  = '{4'b1000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 1'b0, 32'h00F0_00F0};
      vecs[8]  = '{4'b1001, 32'hF000_0000, 32'h0000_000F, 5'd0, 1'b0, 32'hF000_000F};
      vecs[9]  = '{4'b1010, 32'hAAAA_AAAA, 32'hFFFF_0000, 5'd0, 1'b0, 32'h5555_AAAA};
      vecs[10] = '{4'b1100, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 1'b0, 32'h0000_0000};
      vecs[11] = '{4'b0000, 32'h0000_0020, 32'h0000_0077, 5'd9, 1'b1, 32'h0000_0077};

      i_reset = 1'b1; i_valid = 1'b0; i_alu_code = '0; i_dato_a = '0; i_dato_b = '0;
      i_shamt = '0; i_shift_var = 1'b0;
      repeat (3) @(posedge i_clock);
      @(negedge i_clock);
      i_reset = 1'b0;

      // Reset state held while idle
      for (int c = 0; c < 10; c++) begin
         @(negedge i_clock);
         check("rst_ready", 32'(o_ready), 32'd1);
         check("rst_valid", 32'(o_valid), 32'd0);
         check("rst_result", o_result, 32'd0);
         check("rst_zero", 32'(o_zero), 32'd1);
      end

      // Table ops back-to-back: one accept and one result per cycle
      for (int i = 0; i <= 12; i++) begin
         @(negedge i_clock);
         if (i > 0) begin
            check($sformatf("vec%0d_valid", i - 1), 32'(o_valid), 32'd1);
            check($sformatf("vec%0d_result", i - 1), o_result, vecs[i - 1].exp);
            check($sformatf("vec%0d_zero", i - 1), 32'(o_zero), 32'(vecs[i - 1].exp == 0));
            check($sformatf("vec%0d_ready", i - 1), 32'(o_ready), 32'd1);
         end
         if (i < 12) begin
            i_valid     = 1'b1;
            i_alu_code  = vecs[i].code;
            i_dato_a    = vecs[i].a;
            i_dato_b    = vecs[i].b;
            i_shamt     = vecs[i].shamt;
            i_shift_var = vecs[i].var_sh;
         end else begin
            i_valid = 1'b0;
         end
      end
      @(negedge i_clock);
      check("b2b_end_pulse", 32'(o_valid), 32'd0);

      // Multi-cycle shifts
      run_op("sra4", 4'b0010, 32'h0, 32'h8000_0000, 5'd4, 1'b0, 32'hF800_0000);
      run_op("sllv3", 4'b0000, 32'h0000_0023, 32'h0000_0001, 5'd0, 1'b1, 32'h0000_0008);
      run_op("srl31", 4'b0001, 32'h0, 32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001);

      // i_valid held with changing operands during a 31-bit sll
      @(negedge i_clock);
      i_valid = 1'b1; i_alu_code = 4'b0000; i_dato_a = 32'h0; i_dato_b = 32'h1;
      i_shamt = 5'd31; i_shift_var = 1'b0;
      @(posedge i_clock);
      seen = 1'b0;
      ha = 32'h0; hb = 32'h0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge i_clock);
         if (o_valid) begin
            check("hold_lat", 32'(k), 32'd32);
            check("hold_result", o_result, 32'h8000_0000);
            check("hold_ready", 32'(o_ready), 32'd1);
            seen = 1'b1;
            break;
         end
         ha = $urandom; hb = $urandom;
         i_alu_code = 4'b0110; i_dato_a = ha; i_dato_b = hb; i_shamt = 5'($urandom);
      end
      check("hold_seen", 32'(seen), 32'd1);
      @(posedge i_clock);
      @(negedge i_clock);
      i_valid = 1'b0;
      check("hold_next_valid", 32'(o_valid), 32'd1);
      check("hold_next_result", o_result, ha + hb);

      // Reset in the middle of a 10-bit srl
      @(negedge i_clock);
      i_valid = 1'b1; i_alu_code = 4'b0001; i_dato_b = 32'hFFFF_0000;
      i_shamt = 5'd10; i_shift_var = 1'b0;
      @(posedge i_clock);
      @(negedge i_clock);
      i_valid = 1'b0;
      @(negedge i_clock);
      @(negedge i_clock);
      i_reset = 1'b1;
      @(negedge i_clock);
      i_reset = 1'b0;
      check("midrst_ready", 32'(o_ready), 32'd1);
      check("midrst_valid", 32'(o_valid), 32'd0);
      check("midrst_result", o_result, 32'd0);
      check("midrst_zero", 32'(o_zero), 32'd1);
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge i_clock);
         if (o_valid) seen = 1'b1;
      end
      check("midrst_no_valid", 32'(seen), 32'd0);
      run_op("post_rst_addu", 4'b0110, 32'd40, 32'd2, 5'd0, 1'b0, 32'd42);

      // Random operations against the reference model
      for (int r = 0; r < 150; r++) begin
         logic [3:0]  code;
         logic [31:0] a;
         logic [31:0] b;
         logic [4:0]  sh;
         logic        vs;
         int          n;
         code = 4'($urandom_range(0, 15));
         a = $urandom; b = $urandom;
         sh = 5'($urandom); vs = 1'($urandom);
         if (r % 5 == 0) a = b;
         n = vs ? int'(a[4:0]) : int'(sh);
         run_op($sformatf("rnd%0d_op%0d", r, code), code, a, b, sh, vs,
                ref_result(code, a, b, n));
      end

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
